// File: rtl/count_down_timer_pkg.sv
// Shared FSM states, edit-field codes, BCD limits and the wrapping BCD increment
// for the countdown timer front end.
package count_down_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_H,
        ST_EDIT_M,
        ST_EDIT_S,
        ST_LOAD_PLAY,
        ST_RUN,
        ST_PAUSE,
        ST_ALARM
    } state_e;

    localparam logic [1:0] EF_NONE = 2'd0;
    localparam logic [1:0] EF_HOUR = 2'd1;
    localparam logic [1:0] EF_MIN  = 2'd2;
    localparam logic [1:0] EF_SEC  = 2'd3;

    localparam logic [7:0] HOUR_MAX    = 8'h23;
    localparam logic [7:0] MIN_SEC_MAX = 8'h59;

    // Values at or beyond the limit wrap to zero so a corrupted field self-heals.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
        logic [7:0] res;
        if (value >= max) begin
            res = 8'h00;
        end else if (value[3:0] >= 4'd9) begin
            res = {value[7:4] + 4'd1, 4'h0};
        end else begin
            res = value + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/count_down_timer_ctrl_key_debounce.sv
// Key debouncer: 2-flop synchronizer, stable-level counter, one-cycle press pulse.
// Latency: DEBOUNCE_MS+2 cycles from a stable raw level to key_press.
// Backpressure: none; pulses are fire-and-forget.
module key_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk_1k,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_lvl,
    output logic key_press
);

    localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic lvl_q, lvl_d;
    logic press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only advances while the synchronized level disagrees with the
    // accepted level, so any bounce back restarts the qualification window.
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d   = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1k) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_lvl   = lvl_q;
    assign key_press = press_q;

endmodule

// File: rtl/count_down_timer_ctrl.sv
// Countdown timer front end: debounced keys, edit/run FSM, BCD preset, set/play/stop pulses.
// Latency: command pulse registered one cycle after the press event; optional KEY_REPEAT_EN adds inc auto-repeat.
// Backpressure: none; the timer must accept every one-cycle command pulse.
module count_down_timer_ctrl
    import count_down_timer_pkg::*;
#(
    parameter int DEBOUNCE_MS      = 20,
    parameter int ALARM_TIMEOUT_MS = 10000,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_RATE_MS   = 100
) (
    input  logic       clk_1k,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_start,
    input  logic       counting,
    input  logic       ring,
    output logic       set,
    output logic       play,
    output logic       stop,
    output logic [7:0] hour_bcd_in,
    output logic [7:0] minute_bcd_in,
    output logic [7:0] second_bcd_in,
    output logic [1:0] edit_field,
    output logic       alarm_active
);

    localparam int TMO_W = (ALARM_TIMEOUT_MS > 1) ? $clog2(ALARM_TIMEOUT_MS) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALARM_TIMEOUT_MS - 1);

    logic mode_press, inc_press, start_press;
    logic mode_lvl, inc_lvl, start_lvl;
    logic inc_ev, in_edit, preset_nz, unused_lvl;

    state_e state_q, state_d;
    logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic set_q, set_d, play_q, play_d, stop_q, stop_d;
    logic ring_q, ring_d, counting_q, counting_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_mode (
        .clk_1k(clk_1k), .rst_n(rst_n), .key_raw(key_mode), .key_lvl(mode_lvl), .key_press(mode_press)
    );
    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_inc (
        .clk_1k(clk_1k), .rst_n(rst_n), .key_raw(key_inc), .key_lvl(inc_lvl), .key_press(inc_press)
    );
    key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start (
        .clk_1k(clk_1k), .rst_n(rst_n), .key_raw(key_start), .key_lvl(start_lvl), .key_press(start_press)
    );

    assign in_edit   = state_q inside {ST_EDIT_H, ST_EDIT_M, ST_EDIT_S};
    assign preset_nz = |{hour_q, min_q, sec_q};

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int REP_W = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY_MS - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE_MS - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic rep_armed_q, rep_armed_d, rep_fire;

    // First repeat waits the long delay, then the armed flag switches to the short period.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (!inc_lvl || !in_edit) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (rep_cnt_q == (rep_armed_q ? REP_RATE_LAST : REP_DELAY_LAST)) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
            rep_fire    = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_1k) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end

    assign inc_ev     = inc_press | rep_fire;
    assign unused_lvl = mode_lvl ^ start_lvl;
`else
    localparam int unused_repeat_ms = REPEAT_DELAY_MS + REPEAT_RATE_MS;
    assign inc_ev     = inc_press;
    assign unused_lvl = mode_lvl ^ start_lvl ^ inc_lvl;
`endif

    // if/else order inside each state encodes start > mode > inc.
    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        set_d      = 1'b0;
        play_d     = 1'b0;
        stop_d     = 1'b0;
        ring_d     = ring;
        counting_d = counting;
        tmo_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    if (preset_nz) begin
                        set_d   = 1'b1;
                        state_d = ST_LOAD_PLAY;
                    end
                end else if (mode_press) begin
                    state_d = ST_EDIT_H;
                end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (start_press) begin
                    set_d   = 1'b1;
                    state_d = preset_nz ? ST_LOAD_PLAY : ST_IDLE;
                end else if (mode_press) begin
                    case (state_q)
                        ST_EDIT_H: state_d = ST_EDIT_M;
                        ST_EDIT_M: state_d = ST_EDIT_S;
                        default: begin
                            set_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end else if (inc_ev) begin
                    case (state_q)
                        ST_EDIT_H: hour_d = bcd_inc(hour_q, HOUR_MAX);
                        ST_EDIT_M: min_d  = bcd_inc(min_q, MIN_SEC_MAX);
                        default:   sec_d  = bcd_inc(sec_q, MIN_SEC_MAX);
                    endcase
                end
            end
            ST_LOAD_PLAY: begin
                play_d  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_press) begin
                    stop_d  = 1'b1;
                    state_d = ST_PAUSE;
                end else if (ring && !ring_q) begin
                    state_d = ST_ALARM;
                end else if (counting_q && !counting && !ring) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (start_press) begin
                    play_d  = 1'b1;
                    state_d = ST_RUN;
                end else if (mode_press) begin
                    set_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ALARM: begin
                if (start_press || mode_press || inc_press || (tmo_q == TMO_LAST)) begin
                    set_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1k) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hour_q     <= 8'h00;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            set_q      <= 1'b0;
            play_q     <= 1'b0;
            stop_q     <= 1'b0;
            ring_q     <= 1'b0;
            counting_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            set_q      <= set_d;
            play_q     <= play_d;
            stop_q     <= stop_d;
            ring_q     <= ring_d;
            counting_q <= counting_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        edit_field = EF_NONE;
        case (state_q)
            ST_EDIT_H: edit_field = EF_HOUR;
            ST_EDIT_M: edit_field = EF_MIN;
            ST_EDIT_S: edit_field = EF_SEC;
            default:   edit_field = EF_NONE;
        endcase
    end

    assign alarm_active  = (state_q == ST_ALARM);
    assign set           = set_q;
    assign play          = play_q;
    assign stop          = stop_q;
    assign hour_bcd_in   = hour_q;
    assign minute_bcd_in = min_q;
    assign second_bcd_in = sec_q;

endmodule

// File: tb/tb_count_down_timer_ctrl.sv
// Scenario bench for count_down_timer_ctrl: command pulses go through an expected/observed queue pair.
module tb_count_down_timer_ctrl;

    localparam int DB  = 20;
    localparam int TMO = 10000;
    localparam logic [2:0] C_SET  = 3'b100;
    localparam logic [2:0] C_PLAY = 3'b010;
    localparam logic [2:0] C_STOP = 3'b001;
    localparam logic [2:0] K_START = 3'b100;
    localparam logic [2:0] K_MODE  = 3'b010;
    localparam logic [2:0] K_INC   = 3'b001;

    logic clk_1k = 1'b0;
    logic rst_n = 1'b0;
    logic key_mode = 1'b0, key_inc = 1'b0, key_start = 1'b0;
    logic counting = 1'b0, ring = 1'b0;
    logic set, play, stop;
    logic [7:0] hour_bcd_in, minute_bcd_in, second_bcd_in;
    logic [1:0] edit_field;
    logic alarm_active;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [23:0] bcd;
        logic [23:0] prev;
        logic [31:0] gap;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t obs_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cyc = 0;
    logic [23:0] prev_bcd = '0;
    logic [7:0] mh = 8'h00, mm = 8'h00, ms = 8'h00;

    always #5 clk_1k = ~clk_1k;

    count_down_timer_ctrl #(
        .DEBOUNCE_MS(DB), .ALARM_TIMEOUT_MS(TMO), .REPEAT_DELAY_MS(500), .REPEAT_RATE_MS(100)
    ) dut (
        .clk_1k(clk_1k), .rst_n(rst_n),
        .key_mode(key_mode), .key_inc(key_inc), .key_start(key_start),
        .counting(counting), .ring(ring),
        .set(set), .play(play), .stop(stop),
        .hour_bcd_in(hour_bcd_in), .minute_bcd_in(minute_bcd_in), .second_bcd_in(second_bcd_in),
        .edit_field(edit_field), .alarm_active(alarm_active)
    );

    // Decimal reference increment, independent of nibble manipulation.
    function automatic logic [7:0] ref_inc(input logic [7:0] v, input int modulo);
        int d;
        d = (int'(v[7:4]) * 10 + int'(v[3:0]) + 1) % modulo;
        return 8'(((d / 10) * 16) + (d % 10));
    endfunction

    function automatic void push_exp(input logic [2:0] cmd, input int gap);
        pulse_t e;
        e.cmd  = cmd;
        e.bcd  = {mh, mm, ms};
        e.prev = {mh, mm, ms};
        e.gap  = 32'(gap);
        exp_q.push_back(e);
    endfunction

    // Advance n cycles; every command pulse seen at a falling edge is logged.
    task automatic step(input int n);
        pulse_t p;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_1k);
            cyc++;
            if (set || play || stop) begin
                p.cmd  = {set, play, stop};
                p.bcd  = {hour_bcd_in, minute_bcd_in, second_bcd_in};
                p.prev = prev_bcd;
                p.gap  = 32'(cyc - last_cyc);
                last_cyc = cyc;
                obs_q.push_back(p);
            end
            prev_bcd = {hour_bcd_in, minute_bcd_in, second_bcd_in};
        end
    endtask

    task automatic press(input logic [2:0] k);
        {key_start, key_mode, key_inc} = k;
        step(DB + 4);
        {key_start, key_mode, key_inc} = 3'b000;
        step(DB + 4);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        total++;
        if ({set, play, stop} !== 3'b000) begin
            bad++; $display("FAIL reset_cmds: got %b, want 000", {set, play, stop});
        end
        total++;
        if ({hour_bcd_in, minute_bcd_in, second_bcd_in} !== 24'h000000) begin
            bad++; $display("FAIL reset_bcd: got %h, want 000000", {hour_bcd_in, minute_bcd_in, second_bcd_in});
        end
        total++;
        if (edit_field !== 2'd0 || alarm_active !== 1'b0) begin
            bad++; $display("FAIL reset_state: got ef=%0d alarm=%b, want ef=0 alarm=0", edit_field, alarm_active);
        end
        rst_n = 1'b1;
        step(2);
        key_mode = 1'b1;
        step(5);
        key_mode = 1'b0;
        step(40);
        total++;
        if (edit_field !== 2'd0) begin
            bad++; $display("FAIL glitch_ef: got %0d, want 0", edit_field);
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++; $display("FAIL glitch_pulses: got %0d, want 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_edit();
        pulse_t e, o;
        press(K_MODE);
        total++;
        if (edit_field !== 2'd1) begin bad++; $display("FAIL edit_ef_h: got %0d, want 1", edit_field); end
        repeat (2) begin press(K_INC); mh = ref_inc(mh, 24); end
        total++;
        if (hour_bcd_in !== mh) begin bad++; $display("FAIL edit_hour: got %h, want %h", hour_bcd_in, mh); end
        press(K_MODE);
        total++;
        if (edit_field !== 2'd2) begin bad++; $display("FAIL edit_ef_m: got %0d, want 2", edit_field); end
        repeat (60) begin press(K_INC); mm = ref_inc(mm, 60); end
        total++;
        if (minute_bcd_in !== mm) begin bad++; $display("FAIL edit_min_wrap: got %h, want %h", minute_bcd_in, mm); end
        press(K_MODE);
        total++;
        if (edit_field !== 2'd3) begin bad++; $display("FAIL edit_ef_s: got %0d, want 3", edit_field); end
        repeat (3) begin press(K_INC); ms = ref_inc(ms, 60); end
        press(K_MODE);
        push_exp(C_SET, 0);
        total++;
        if (edit_field !== 2'd0) begin bad++; $display("FAIL edit_ef_idle: got %0d, want 0", edit_field); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o.cmd !== e.cmd || o.bcd !== e.bcd || o.prev !== e.prev || (e.gap != 0 && o.gap != e.gap)) begin
                bad++;
                $display("FAIL edit_cmd: got cmd=%b bcd=%h prev=%h gap=%0d, want cmd=%b bcd=%h gap=%0d",
                         o.cmd, o.bcd, o.prev, o.gap, e.cmd, e.bcd, e.gap);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL edit_extra: got %0d pulses, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_wrap();
        pulse_t e, o;
        press(K_MODE);
        while (mh != 8'h23) begin press(K_INC); mh = ref_inc(mh, 24); end
        total++;
        if (hour_bcd_in !== mh) begin bad++; $display("FAIL wrap_hour_max: got %h, want %h", hour_bcd_in, mh); end
        press(K_INC); mh = ref_inc(mh, 24);
        total++;
        if (hour_bcd_in !== mh) begin bad++; $display("FAIL wrap_hour: got %h, want %h", hour_bcd_in, mh); end
        press(K_MODE);
        press(K_MODE);
        while (ms != 8'h09) begin press(K_INC); ms = ref_inc(ms, 60); end
        press(K_INC); ms = ref_inc(ms, 60);
        total++;
        if (second_bcd_in !== ms) begin bad++; $display("FAIL wrap_sec_carry: got %h, want %h", second_bcd_in, ms); end
        press(K_MODE);
        push_exp(C_SET, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o.cmd !== e.cmd || o.bcd !== e.bcd || o.prev !== e.prev || (e.gap != 0 && o.gap != e.gap)) begin
                bad++;
                $display("FAIL wrap_cmd: got cmd=%b bcd=%h prev=%h gap=%0d, want cmd=%b bcd=%h gap=%0d",
                         o.cmd, o.bcd, o.prev, o.gap, e.cmd, e.bcd, e.gap);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL wrap_extra: got %0d pulses, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_start_pause();
        pulse_t e, o;
        press(K_START);
        push_exp(C_SET, 0);
        push_exp(C_PLAY, 1);
        counting = 1'b1;
        press(K_START);
        push_exp(C_STOP, 0);
        press(K_START);
        push_exp(C_PLAY, 0);
        press(K_START);
        push_exp(C_STOP, 0);
        press(K_MODE);
        push_exp(C_SET, 0);
        counting = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o.cmd !== e.cmd || o.bcd !== e.bcd || o.prev !== e.prev || (e.gap != 0 && o.gap != e.gap)) begin
                bad++;
                $display("FAIL run_cmd: got cmd=%b bcd=%h prev=%h gap=%0d, want cmd=%b bcd=%h gap=%0d",
                         o.cmd, o.bcd, o.prev, o.gap, e.cmd, e.bcd, e.gap);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL run_extra: got %0d pulses, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_alarm();
        pulse_t e, o;
        int n_high;
        bit done;
        press(K_START);
        push_exp(C_SET, 0);
        push_exp(C_PLAY, 1);
        counting = 1'b1;
        step(3);
        ring = 1'b1;
        counting = 1'b0;
        step(2);
        total++;
        if (alarm_active !== 1'b1) begin bad++; $display("FAIL alarm_enter: got %b, want 1", alarm_active); end
        push_exp(C_SET, 0);
        n_high = 2;
        done = 1'b0;
        for (int i = 0; i < TMO + 2000 && !done; i++) begin
            step(1);
            if (alarm_active) n_high++;
            else done = 1'b1;
        end
        total++;
        if (n_high != TMO) begin bad++; $display("FAIL alarm_timeout: got %0d cycles, want %0d", n_high, TMO); end
        ring = 1'b0;
        step(2);
        total++;
        if (alarm_active !== 1'b0 || edit_field !== 2'd0) begin
            bad++; $display("FAIL alarm_exit: got alarm=%b ef=%0d, want 0 0", alarm_active, edit_field);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o.cmd !== e.cmd || o.bcd !== e.bcd || o.prev !== e.prev || (e.gap != 0 && o.gap != e.gap)) begin
                bad++;
                $display("FAIL alarm_cmd: got cmd=%b bcd=%h prev=%h gap=%0d, want cmd=%b bcd=%h gap=%0d",
                         o.cmd, o.bcd, o.prev, o.gap, e.cmd, e.bcd, e.gap);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL alarm_extra: got %0d pulses, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        pulse_t e, o;
        int n_before;
        press(K_START);
        push_exp(C_SET, 0);
        push_exp(C_PLAY, 1);
        counting = 1'b1;
        step(3);
        n_before = obs_q.size();
        press(K_MODE | K_INC);
        total++;
        if (obs_q.size() != n_before || edit_field !== 2'd0) begin
            bad++; $display("FAIL run_ignore: got %0d pulses ef=%0d, want %0d pulses ef=0", obs_q.size(), edit_field, n_before);
        end
        counting = 1'b0;
        step(3);
        press(K_START | K_MODE);
        push_exp(C_SET, 0);
        push_exp(C_PLAY, 1);
        total++;
        if (edit_field !== 2'd0) begin bad++; $display("FAIL simul_ef: got %0d, want 0", edit_field); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            total++;
            if (o.cmd !== e.cmd || o.bcd !== e.bcd || o.prev !== e.prev || (e.gap != 0 && o.gap != e.gap)) begin
                bad++;
                $display("FAIL simul_cmd: got cmd=%b bcd=%h prev=%h gap=%0d, want cmd=%b bcd=%h gap=%0d",
                         o.cmd, o.bcd, o.prev, o.gap, e.cmd, e.bcd, e.gap);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL simul_extra: got %0d pulses, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        key_start = 1'b1;
        mh = 8'h00; mm = 8'h00; ms = 8'h00;
        step(1);
        total++;
        if ({hour_bcd_in, minute_bcd_in, second_bcd_in} !== {mh, mm, ms}) begin
            bad++; $display("FAIL midrst_bcd: got %h, want %h", {hour_bcd_in, minute_bcd_in, second_bcd_in}, {mh, mm, ms});
        end
        total++;
        if ({set, play, stop} !== 3'b000 || edit_field !== 2'd0 || alarm_active !== 1'b0) begin
            bad++; $display("FAIL midrst_out: got cmds=%b ef=%0d alarm=%b, want 000 0 0", {set, play, stop}, edit_field, alarm_active);
        end
        step(DB + 4);
        key_start = 1'b0;
        rst_n = 1'b1;
        step(DB + 4);
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL midrst_pulses: got %0d, want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_edit();
        test_wrap();
        test_start_pause();
        test_alarm();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
